// File: rtl/pipeline_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_ctrl_if
//  Description : Bundle of the signals exchanged between the pipeline stages
//                and the pipeline sequencing controller.
//                master : pipeline side, drives stage status and reads the
//                         stall/flush controls.
//                slave  : controller side.
//                Stage status : id_valid, id_rs1, id_rs2, id_uses_rs1,
//                               id_uses_rs2, ex_valid, ex_is_load, ex_rd,
//                               ex_redirect, mem_req, mem_ack, perf_clr
//                Controls     : if_stall, id_stall, ex_stall, if_flush,
//                               id_flush, state, stall_cycles
//  Revision    : 1.0  initial release
// ============================================================================
interface pipeline_ctrl_if;
    logic        id_valid;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic        id_uses_rs1;
    logic        id_uses_rs2;
    logic        ex_valid;
    logic        ex_is_load;
    logic [4:0]  ex_rd;
    logic        ex_redirect;
    logic        mem_req;
    logic        mem_ack;
    logic        perf_clr;

    logic        if_stall;
    logic        id_stall;
    logic        ex_stall;
    logic        if_flush;
    logic        id_flush;
    logic [1:0]  state;
    logic [15:0] stall_cycles;

    modport master (
        output id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
               ex_valid, ex_is_load, ex_rd, ex_redirect,
               mem_req, mem_ack, perf_clr,
        input  if_stall, id_stall, ex_stall, if_flush, id_flush,
               state, stall_cycles
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
               ex_valid, ex_is_load, ex_rd, ex_redirect,
               mem_req, mem_ack, perf_clr,
        output if_stall, id_stall, ex_stall, if_flush, id_flush,
               state, stall_cycles
    );
endinterface
`default_nettype wire

// File: rtl/pipeline_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_ctrl
//  Description : Stall/flush sequencer for the five-stage core. Decides the
//                IF/ID, ID/EX and EX/MEM holds and bubbles from load-use
//                hazards, EX redirects and the data-memory handshake, and
//                keeps a saturating count of cycles with if_stall high.
//  Ports       : clk  - core clock, rising edge
//                rst  - asynchronous active-high reset
//                bus  - pipeline_ctrl_if.slave (stage status in, controls out)
//  Revision    : 1.0  initial release
// ============================================================================
module pipeline_ctrl (
    input  wire logic          clk,
    input  wire logic          rst,
    pipeline_ctrl_if.slave     bus
);

    localparam logic [1:0] c_RUN      = 2'd0;
    localparam logic [1:0] c_MEM_WAIT = 2'd1;
    localparam logic [1:0] c_REDIRECT = 2'd2;
    localparam logic [15:0] c_CNT_MAX = 16'hFFFF;

    logic [1:0]  state_q,            state_d;
    logic        redirect_pending_q, redirect_pending_d;
    logic [15:0] stall_cycles_q,     stall_cycles_d;

    logic w_load_use;
    logic w_mem_wait;
    logic w_if_stall;
    logic w_id_stall;
    logic w_ex_stall;
    logic w_if_flush;
    logic w_id_flush;

    // x0 is never a real dependency, so a load targeting it cannot hazard.
    assign w_load_use = bus.ex_valid & bus.ex_is_load & (bus.ex_rd != 5'd0) &
                        bus.id_valid &
                        ((bus.id_uses_rs1 & (bus.id_rs1 == bus.ex_rd)) |
                         (bus.id_uses_rs2 & (bus.id_rs2 == bus.ex_rd)));

    assign w_mem_wait = bus.mem_req & ~bus.mem_ack;

    always_comb begin
        state_d            = state_q;
        redirect_pending_d = redirect_pending_q;
        w_if_stall         = 1'b0;
        w_id_stall         = 1'b0;
        w_ex_stall         = 1'b0;
        w_if_flush         = 1'b0;
        w_id_flush         = 1'b0;

        case (state_q)
            c_RUN: begin
                if (w_mem_wait) begin
                    // A simultaneous redirect is not latched: EX is frozen,
                    // so ex_redirect is presented again after release.
                    w_if_stall = 1'b1;
                    w_id_stall = 1'b1;
                    w_ex_stall = 1'b1;
                    state_d    = c_MEM_WAIT;
                end else if (bus.ex_redirect) begin
                    w_if_flush = 1'b1;
                    w_id_flush = 1'b1;
                    state_d    = c_REDIRECT;
                end else if (w_load_use) begin
                    // One bubble: the load reaches MEM next cycle and its
                    // result can be forwarded from there.
                    w_if_stall = 1'b1;
                    w_id_stall = 1'b1;
                    w_id_flush = 1'b1;
                end
            end

            c_MEM_WAIT: begin
                if (w_mem_wait) begin
                    w_if_stall = 1'b1;
                    w_id_stall = 1'b1;
                    w_ex_stall = 1'b1;
                end else begin
                    // Released this cycle; resume the flush that the memory
                    // stall interrupted, if any.
                    state_d            = redirect_pending_q ? c_REDIRECT : c_RUN;
                    redirect_pending_d = 1'b0;
                end
            end

            c_REDIRECT: begin
                if (w_mem_wait) begin
                    // IF/ID still holds a wrong-path fetch; remember to flush
                    // it once memory releases the pipeline.
                    w_if_stall         = 1'b1;
                    w_id_stall         = 1'b1;
                    w_ex_stall         = 1'b1;
                    redirect_pending_d = 1'b1;
                    state_d            = c_MEM_WAIT;
                end else begin
                    w_if_flush = 1'b1;
                    w_id_flush = 1'b1;
                    state_d    = bus.ex_redirect ? c_REDIRECT : c_RUN;
                end
            end

            default: begin
                state_d            = c_RUN;
                redirect_pending_d = 1'b0;
            end
        endcase
    end

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (bus.perf_clr) begin
            stall_cycles_d = 16'd0;
        end else if (w_if_stall && (stall_cycles_q != c_CNT_MAX)) begin
            stall_cycles_d = stall_cycles_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q            <= c_RUN;
            redirect_pending_q <= 1'b0;
            stall_cycles_q     <= 16'd0;
        end else begin
            state_q            <= state_d;
            redirect_pending_q <= redirect_pending_d;
            stall_cycles_q     <= stall_cycles_d;
        end
    end

    assign bus.if_stall     = w_if_stall;
    assign bus.id_stall     = w_id_stall;
    assign bus.ex_stall     = w_ex_stall;
    assign bus.if_flush     = w_if_flush;
    assign bus.id_flush     = w_id_flush;
    assign bus.state        = state_q;
    assign bus.stall_cycles = stall_cycles_q;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipeline_ctrl
//  Description : Self-checking bench for pipeline_ctrl: single-cycle vector
//                table, hand-written multi-cycle sequences, and a randomized
//                run against a behavioural model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pipeline_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipeline_ctrl_if bus();

    pipeline_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    // model state: 0 RUN, 1 MEM_WAIT, 2 REDIRECT
    int m_st;
    bit m_pend;
    int m_cnt;

    typedef struct {
        logic       idv;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic       exv;
        logic       exl;
        logic [4:0] rd;
        logic       redir;
        logic       mreq;
        logic       mack;
        logic [4:0] exp_out;   // {if_stall,id_stall,ex_stall,if_flush,id_flush}
    } vec_t;

    vec_t tbl[14];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [4:0] outs();
        return {bus.if_stall, bus.id_stall, bus.ex_stall, bus.if_flush, bus.id_flush};
    endfunction

    task automatic idle();
        bus.id_valid    = 1'b0;
        bus.id_rs1      = 5'd0;
        bus.id_rs2      = 5'd0;
        bus.id_uses_rs1 = 1'b0;
        bus.id_uses_rs2 = 1'b0;
        bus.ex_valid    = 1'b0;
        bus.ex_is_load  = 1'b0;
        bus.ex_rd       = 5'd0;
        bus.ex_redirect = 1'b0;
        bus.mem_req     = 1'b0;
        bus.mem_ack     = 1'b0;
        bus.perf_clr    = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Called just after inputs are applied at a negedge.
    task automatic expect_cyc(input string tag, input logic [4:0] e_out,
                              input int e_st, input int e_cnt);
        #1;
        chk({tag, "/outs"},  int'(outs()), int'(e_out));
        chk({tag, "/state"}, int'(bus.state), e_st);
        chk({tag, "/cnt"},   int'(bus.stall_cycles), e_cnt);
    endtask

    // Behavioural reference: derives the expected controls from the bubble
    // rules, checks them, then advances the model to the next edge.
    task automatic model_step();
        bit lu, mw;
        logic [4:0] e;
        int nst;
        bit npend;
        #1;
        if (rst) begin
            m_st = 0; m_pend = 0; m_cnt = 0;
        end
        lu = bus.ex_valid && bus.ex_is_load && (bus.ex_rd != 0) && bus.id_valid &&
             ((bus.id_uses_rs1 && bus.id_rs1 == bus.ex_rd) ||
              (bus.id_uses_rs2 && bus.id_rs2 == bus.ex_rd));
        mw = bus.mem_req && !bus.mem_ack;
        e = 5'b00000;
        nst = m_st;
        npend = m_pend;
        if (mw) begin
            e = 5'b11100;
            nst = 1;
            if (m_st == 2) npend = 1;
        end else if (m_st == 1) begin
            nst = m_pend ? 2 : 0;
            npend = 0;
        end else if (m_st == 2 || bus.ex_redirect) begin
            e = 5'b00011;
            nst = bus.ex_redirect ? 2 : 0;
        end else if (lu) begin
            e = 5'b11001;
        end
        chk("rand/outs",  int'(outs()), int'(e));
        chk("rand/state", int'(bus.state), m_st);
        chk("rand/cnt",   int'(bus.stall_cycles), m_cnt);
        if (!rst) begin
            if (bus.perf_clr)                    m_cnt = 0;
            else if (e[4] && m_cnt < 65535)      m_cnt = m_cnt + 1;
            m_st = nst;
            m_pend = npend;
        end
    endtask

    initial begin
        rst = 1'b1;
        idle();

        //                 idv rs1  rs2  u1 u2 exv exl rd   rdr mrq mak  expected
        tbl[0]  = '{1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'b00000};
        tbl[1]  = '{1'b1, 5'd7, 5'd2, 1'b1, 1'b0, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 5'b11001};
        tbl[2]  = '{1'b1, 5'd1, 5'd7, 1'b1, 1'b0, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 5'b00000};
        tbl[3]  = '{1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 5'b00000};
        tbl[4]  = '{1'b1, 5'd7, 5'd2, 1'b1, 1'b0, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 5'b00000};
        tbl[5]  = '{1'b0, 5'd7, 5'd2, 1'b1, 1'b0, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 5'b00000};
        tbl[6]  = '{1'b1, 5'd7, 5'd2, 1'b1, 1'b0, 1'b1, 1'b0, 5'd7, 1'b0, 1'b0, 1'b0, 5'b00000};
        tbl[7]  = '{1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 5'b11100};
        tbl[8]  = '{1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 5'b00000};
        tbl[9]  = '{1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 5'b00011};
        tbl[10] = '{1'b1, 5'd9, 5'd2, 1'b1, 1'b0, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 5'b00011};
        tbl[11] = '{1'b1, 5'd9, 5'd2, 1'b1, 1'b0, 1'b1, 1'b1, 5'd9, 1'b1, 1'b1, 1'b0, 5'b11100};
        tbl[12] = '{1'b1, 5'd9, 5'd2, 1'b1, 1'b0, 1'b1, 1'b1, 5'd9, 1'b0, 1'b1, 1'b1, 5'b11001};
        tbl[13] = '{1'b1, 5'd3, 5'd31, 1'b0, 1'b1, 1'b1, 1'b1, 5'd31, 1'b0, 1'b0, 1'b0, 5'b11001};

        // Reset state with idle inputs.
        do_reset();
        expect_cyc("reset", 5'b00000, 0, 0);

        for (int i = 0; i < 14; i++) begin
            do_reset();
            bus.id_valid    = tbl[i].idv;
            bus.id_rs1      = tbl[i].rs1;
            bus.id_rs2      = tbl[i].rs2;
            bus.id_uses_rs1 = tbl[i].u1;
            bus.id_uses_rs2 = tbl[i].u2;
            bus.ex_valid    = tbl[i].exv;
            bus.ex_is_load  = tbl[i].exl;
            bus.ex_rd       = tbl[i].rd;
            bus.ex_redirect = tbl[i].redir;
            bus.mem_req     = tbl[i].mreq;
            bus.mem_ack     = tbl[i].mack;
            #1;
            chk($sformatf("vec%0d/outs", i), int'(outs()), int'(tbl[i].exp_out));
        end

        // Load-use: one bubble, counter 0 -> 1.
        do_reset();
        bus.ex_valid = 1; bus.ex_is_load = 1; bus.ex_rd = 5'd5;
        bus.id_valid = 1; bus.id_rs2 = 5'd5; bus.id_uses_rs2 = 1;
        bus.id_rs1 = 5'd3; bus.id_uses_rs1 = 1;
        expect_cyc("lu0", 5'b11001, 0, 0);
        @(negedge clk); bus.ex_valid = 0; bus.ex_is_load = 0;
        expect_cyc("lu1", 5'b00000, 0, 1);

        // Load to x0 with ID reading x0.
        @(negedge clk); idle();
        bus.ex_valid = 1; bus.ex_is_load = 1; bus.ex_rd = 5'd0;
        bus.id_valid = 1; bus.id_uses_rs1 = 1; bus.id_rs1 = 5'd0;
        expect_cyc("x0", 5'b00000, 0, 1);

        // Redirect pulse: two flush cycles.
        do_reset();
        bus.ex_redirect = 1;
        expect_cyc("rd0", 5'b00011, 0, 0);
        @(negedge clk); bus.ex_redirect = 0;
        expect_cyc("rd1", 5'b00011, 2, 0);
        @(negedge clk);
        expect_cyc("rd2", 5'b00000, 0, 0);

        // Memory wait of 3 cycles with a redirect presented alongside.
        do_reset();
        bus.mem_req = 1; bus.ex_redirect = 1;
        expect_cyc("mw0", 5'b11100, 0, 0);
        @(negedge clk); expect_cyc("mw1", 5'b11100, 1, 1);
        @(negedge clk); expect_cyc("mw2", 5'b11100, 1, 2);
        @(negedge clk); bus.mem_ack = 1;
        expect_cyc("mw3", 5'b00000, 1, 3);
        @(negedge clk); bus.mem_req = 0; bus.mem_ack = 0;
        expect_cyc("mw4", 5'b00011, 0, 3);
        @(negedge clk); bus.ex_redirect = 0;
        expect_cyc("mw5", 5'b00011, 2, 3);
        @(negedge clk); expect_cyc("mw6", 5'b00000, 0, 3);

        // Memory wait inside REDIRECT resumes the flush afterwards.
        do_reset();
        bus.ex_redirect = 1;
        expect_cyc("rm0", 5'b00011, 0, 0);
        @(negedge clk); bus.ex_redirect = 0; bus.mem_req = 1;
        expect_cyc("rm1", 5'b11100, 2, 0);
        @(negedge clk); expect_cyc("rm2", 5'b11100, 1, 1);
        @(negedge clk); bus.mem_ack = 1;
        expect_cyc("rm3", 5'b00000, 1, 2);
        @(negedge clk); bus.mem_req = 0; bus.mem_ack = 0;
        expect_cyc("rm4", 5'b00011, 2, 2);
        @(negedge clk); expect_cyc("rm5", 5'b00000, 0, 2);

        // Asynchronous reset in MEM_WAIT discards the pending redirect.
        do_reset();
        bus.ex_redirect = 1;
        @(negedge clk); bus.ex_redirect = 0; bus.mem_req = 1;
        @(negedge clk); idle(); rst = 1;
        expect_cyc("ar0", 5'b00000, 0, 0);
        @(negedge clk); rst = 0; bus.mem_req = 1;
        expect_cyc("ar1", 5'b11100, 0, 0);
        @(negedge clk); bus.mem_ack = 1;
        expect_cyc("ar2", 5'b00000, 1, 1);
        @(negedge clk); idle();
        expect_cyc("ar3", 5'b00000, 0, 1);

        // Counter saturation, then clear with a stall present.
        do_reset();
        bus.mem_req = 1;
        repeat (65540) @(negedge clk);
        expect_cyc("sat0", 5'b11100, 1, 16'hFFFF);
        @(negedge clk); expect_cyc("sat1", 5'b11100, 1, 16'hFFFF);
        @(negedge clk); bus.perf_clr = 1;
        expect_cyc("clr0", 5'b11100, 1, 16'hFFFF);
        @(negedge clk); bus.perf_clr = 0;
        expect_cyc("clr1", 5'b11100, 1, 0);

        // Randomized run against the behavioural model.
        do_reset();
        m_st = 0; m_pend = 0; m_cnt = 0;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            bus.id_valid    = ($urandom_range(0, 3) != 0);
            bus.id_rs1      = 5'($urandom_range(0, 3));
            bus.id_rs2      = 5'($urandom_range(0, 3));
            bus.id_uses_rs1 = 1'($urandom_range(0, 1));
            bus.id_uses_rs2 = 1'($urandom_range(0, 1));
            bus.ex_valid    = ($urandom_range(0, 3) != 0);
            bus.ex_is_load  = 1'($urandom_range(0, 1));
            bus.ex_rd       = 5'($urandom_range(0, 3));
            bus.ex_redirect = ($urandom_range(0, 7) == 0);
            bus.mem_req     = ($urandom_range(0, 3) == 0);
            bus.mem_ack     = 1'($urandom_range(0, 1));
            bus.perf_clr    = ($urandom_range(0, 31) == 0);
            rst             = ($urandom_range(0, 99) == 0);
            model_step();
        end
        @(negedge clk);
        rst = 0;
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Pipeline sequencing controller for the five-stage core. Owns all stall and flush decisions for the IF/ID, ID/EX and EX/MEM boundaries using decoded register usage from ID, load and redirect status from EX, and the data-memory handshake from MEM. It also keeps a saturating stall-cycle performance counter. One instance sits beside the pipeline registers, and every stage register's enable and clear come from it.

## Interface
- No parameters; register index width fixed at 5, counter width fixed at 16.
- clk  in  1  core clock, rising edge
- rst  in  1  asynchronous, active-high reset
- id_valid  in  1  ID stage holds a real instruction
- id_rs1, id_rs2  in  5 each  source register indices of ID instruction
- id_uses_rs1, id_uses_rs2  in  1 each  ID instruction reads rs1 / rs2 (false for LUI, AUIPC, JAL; rs2 false for OPIMM, LOAD, JALR)
- ex_valid  in  1  EX stage holds a real instruction
- ex_is_load  in  1  EX instruction is LOAD
- ex_rd  in  5  EX destination register
- ex_redirect  in  1  taken BRANCH, JAL or JALR resolved in EX this cycle
- mem_req  in  1  MEM stage load/store is issuing to data memory
- mem_ack  in  1  data memory completes the access this cycle
- perf_clr  in  1  synchronous clear of stall_cycles
- if_stall  out  1  hold PC and the IF/ID register
- id_stall  out  1  hold the ID/EX input (ID instruction stays)
- ex_stall  out  1  hold the EX/MEM and MEM/WB registers
- if_flush  out  1  clear IF/ID to a bubble at next edge
- id_flush  out  1  load a bubble into ID/EX at next edge
- state  out  2  0 = RUN, 1 = MEM_WAIT, 2 = REDIRECT
- stall_cycles  out  16  count of cycles with if_stall high

## Operation
- Outputs are combinational from the state register, redirect_pending, and current inputs. The state register, redirect_pending, and stall_cycles are registered.
- load_use = ex_valid & ex_is_load & (ex_rd != 0) & id_valid & ((id_uses_rs1 & id_rs1 == ex_rd) | (id_uses_rs2 & id_rs2 == ex_rd)).
- mem_wait = mem_req & ~mem_ack.
- Priority in every state is mem_wait, then redirect, then load_use.
- RUN:
  - mem_wait: all three stalls high, no flush, go to MEM_WAIT.
  - Else ex_redirect: if_flush = id_flush = 1, no stall, go to REDIRECT.
  - Else load_use: if_stall = id_stall = id_flush = 1, stay in RUN. This produces a single bubble, because the load moves to MEM next cycle.
  - Else all outputs are 0.
- MEM_WAIT:
  - All stalls are high while mem_ack = 0.
  - ex_redirect and load_use are ignored. EX is held, so both are re-evaluated after release.
  - On mem_ack, stalls drop in the same cycle. Go to REDIRECT if redirect_pending, else go to RUN.
- REDIRECT: covers the one-cycle latency of synchronous instruction memory, so the IF/ID register again holds a wrong-path fetch.
  - mem_wait: stalls high, set redirect_pending, go to MEM_WAIT.
  - Else if_flush = id_flush = 1. Go to REDIRECT if ex_redirect (a fresh redirect restarts it), else go to RUN.
  - load_use is ignored.
- redirect_pending is cleared whenever REDIRECT is entered from MEM_WAIT.
- stall_cycles:
  - perf_clr loads 0 and has priority over increment.
  - Otherwise the counter increments on each cycle with if_stall high.
  - It saturates at 0xFFFF with no wrap.

## Timing
- Reset values: state RUN, redirect_pending 0, stall_cycles 0. With all inputs low, every stall and flush output is 0.
- rst asserted mid-operation forces RUN immediately, asynchronously, and discards any pending redirect.
- Stall and flush respond in the same cycle as their cause, with zero latency.
- Penalties:
  - Load-use costs exactly 1 bubble.
  - A redirect costs exactly 2 bubbles: the redirect cycle plus the REDIRECT cycle.
  - A memory access acked N cycles after its first mem_req cycle costs N stall cycles. An ack in the same cycle (N = 0) costs none.
- Simultaneous mem_wait and ex_redirect in RUN: stall only. The redirect is taken on the cycle after release, since ex_redirect is still presented.
- A combinational path from mem_ack to the stalls is intended.

## Test plan
- Load-use: EX holds a load with rd = 5 and ID reads rs2 = 5 with id_uses_rs2 = 1. Required: if_stall, id_stall and id_flush all 1 for one cycle, then 0. stall_cycles goes from 0 to 1.
- Load with rd = 0, ID reading x0: no stall and no flush.
- ex_redirect pulse in RUN: if_flush and id_flush are 1 for 2 consecutive cycles, with state going RUN → REDIRECT → RUN.
- mem_req high with ack after 3 cycles, and ex_redirect also high in the first cycle:
  - All stalls are high for 3 cycles, state MEM_WAIT.
  - On the ack cycle, stalls are 0, then the redirect is flushed for 2 cycles.
  - stall_cycles = 3.
- In REDIRECT, mem_req without ack for 2 cycles, then ack: MEM_WAIT for 2 cycles, then REDIRECT flushes for one cycle, then RUN.
- Saturation and reset:
  - Preload stall_cycles near 0xFFFF, then hold a stall: the counter sticks at 0xFFFF.
  - perf_clr together with a stall gives 0.
  - rst asserted in MEM_WAIT gives state 0 and all outputs 0 before the next edge.
